// File: rtl/controlador_conteo.sv
// controlador_conteo: run/pause/direction controller for an up/down display counter.
// The count advances between programmable limits on each step enable. It has three
// limit policies: wrap, ping-pong and one-shot.
// Ports:
//   clkNexys2  system clock, rising edge
//   Reset      synchronous active-low reset
//   tick       one-cycle step enable
//   iniciar    start/restart button level
//   pausar     pause/resume button level
//   invertir   reverse-direction button level
//   Direccion  start direction (0 up, 1 down)
//   modo       limit policy (00 wrap, 01 ping-pong, 10 one-shot, 11 wrap)
//   limInf     lower limit
//   limSup     upper limit
//   contador   current count (registered)
//   direccion  current direction, 0 up (registered)
//   activo     high while counting up or down (registered)
//   terminal   one-cycle pulse after a limit step (registered)
//   error      sticky flag, set when a start is attempted with limInf > limSup
//   estado     00 PARADO, 01 SUBIENDO, 10 BAJANDO, 11 PAUSA
module controlador_conteo #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clkNexys2,
    input  logic             Reset,
    input  logic             tick,
    input  logic             iniciar,
    input  logic             pausar,
    input  logic             invertir,
    input  logic             Direccion,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] limInf,
    input  logic [WIDTH-1:0] limSup,
    output logic [WIDTH-1:0] contador,
    output logic             direccion,
    output logic             activo,
    output logic             terminal,
    output logic             error,
    output logic [1:0]       estado
);

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        SUBIENDO = 2'b01,
        BAJANDO  = 2'b10,
        PAUSA    = 2'b11
    } estado_t;

    estado_t          estado_q, estado_nxt;
    logic             prev_ini, prev_pau, prev_inv;
    logic             ini_edge, pau_edge, inv_edge;
    logic             limites_ok, en_sup, en_inf, paso;
    logic [WIDTH-1:0] contador_nxt;
    logic             direccion_nxt, activo_nxt, terminal_nxt, error_nxt;

    assign ini_edge   = iniciar  & ~prev_ini;
    assign pau_edge   = pausar   & ~prev_pau;
    assign inv_edge   = invertir & ~prev_inv;
    assign limites_ok = (limInf <= limSup);
    // Values beyond a limit (limits moved mid-run) count as being at that limit.
    assign en_sup     = (contador >= limSup);
    assign en_inf     = (contador <= limInf);
    // A tick only steps the count when no higher-priority button edge is present.
    assign paso       = tick & ~ini_edge & ~pau_edge & ~inv_edge;
    assign estado     = estado_q;

    // State register
    always_ff @(posedge clkNexys2) begin
        if (!Reset) begin
            estado_q <= PARADO;
        end else begin
            estado_q <= estado_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        estado_nxt = estado_q;
        if (ini_edge) begin
            if (!limites_ok)    estado_nxt = PARADO;
            else if (Direccion) estado_nxt = BAJANDO;
            else                estado_nxt = SUBIENDO;
        end else begin
            case (estado_q)
                SUBIENDO: begin
                    if (pau_edge)      estado_nxt = PAUSA;
                    else if (inv_edge) estado_nxt = BAJANDO;
                    else if (tick && en_sup) begin
                        if (modo == 2'b01)      estado_nxt = BAJANDO;
                        else if (modo == 2'b10) estado_nxt = PARADO;
                    end
                end
                BAJANDO: begin
                    if (pau_edge)      estado_nxt = PAUSA;
                    else if (inv_edge) estado_nxt = SUBIENDO;
                    else if (tick && en_inf) begin
                        if (modo == 2'b01)      estado_nxt = SUBIENDO;
                        else if (modo == 2'b10) estado_nxt = PARADO;
                    end
                end
                PAUSA: begin
                    // direccion still holds the direction from before the pause
                    if (pau_edge) estado_nxt = direccion ? BAJANDO : SUBIENDO;
                end
                default: estado_nxt = estado_q;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        contador_nxt  = contador;
        terminal_nxt  = 1'b0;
        error_nxt     = error;
        if (ini_edge) begin
            if (limites_ok) begin
                contador_nxt = Direccion ? limSup : limInf;
                error_nxt    = 1'b0;
            end else begin
                error_nxt    = 1'b1;
            end
        end else if (paso && estado_q == SUBIENDO) begin
            if (!en_sup) begin
                contador_nxt = WIDTH'(contador + WIDTH'(1));
            end else begin
                terminal_nxt = 1'b1;
                case (modo)
                    2'b01:   contador_nxt = (limSup > limInf) ? WIDTH'(limSup - WIDTH'(1)) : contador;
                    2'b10:   contador_nxt = contador;
                    default: contador_nxt = limInf;
                endcase
            end
        end else if (paso && estado_q == BAJANDO) begin
            if (!en_inf) begin
                contador_nxt = WIDTH'(contador - WIDTH'(1));
            end else begin
                terminal_nxt = 1'b1;
                case (modo)
                    2'b01:   contador_nxt = (limSup > limInf) ? WIDTH'(limInf + WIDTH'(1)) : contador;
                    2'b10:   contador_nxt = contador;
                    default: contador_nxt = limSup;
                endcase
            end
        end

        // Direction follows the running state; it is held in PAUSA and PARADO.
        direccion_nxt = direccion;
        if (estado_nxt == SUBIENDO)     direccion_nxt = 1'b0;
        else if (estado_nxt == BAJANDO) direccion_nxt = 1'b1;
        activo_nxt = (estado_nxt == SUBIENDO) || (estado_nxt == BAJANDO);
    end

    // Datapath and output registers; button history resets high to block edges from held buttons
    always_ff @(posedge clkNexys2) begin
        if (!Reset) begin
            contador  <= '0;
            direccion <= 1'b0;
            activo    <= 1'b0;
            terminal  <= 1'b0;
            error     <= 1'b0;
            prev_ini  <= 1'b1;
            prev_pau  <= 1'b1;
            prev_inv  <= 1'b1;
        end else begin
            contador  <= contador_nxt;
            direccion <= direccion_nxt;
            activo    <= activo_nxt;
            terminal  <= terminal_nxt;
            error     <= error_nxt;
            prev_ini  <= iniciar;
            prev_pau  <= pausar;
            prev_inv  <= invertir;
        end
    end

endmodule

// File: tb/tb_controlador_conteo.sv
// Testbench for controlador_conteo: directed test-plan sequences followed by random stimulus.
// A reference model pushes the expected outputs into a queue, and a monitor compares them.
module tb_controlador_conteo;

    logic       clk = 1'b0;
    logic       Reset, tick, iniciar, pausar, invertir, Direccion;
    logic [1:0] modo;
    logic [3:0] limInf, limSup;
    logic [3:0] contador;
    logic       direccion, activo, terminal, error;
    logic [1:0] estado;

    controlador_conteo #(.WIDTH(4)) dut (
        .clkNexys2(clk), .Reset(Reset), .tick(tick), .iniciar(iniciar),
        .pausar(pausar), .invertir(invertir), .Direccion(Direccion), .modo(modo),
        .limInf(limInf), .limSup(limSup), .contador(contador), .direccion(direccion),
        .activo(activo), .terminal(terminal), .error(error), .estado(estado)
    );

    always #5 clk = ~clk;

    localparam int ST_PARADO = 0, ST_SUB = 1, ST_BAJ = 2, ST_PAUSA = 3;

    typedef struct {
        int cnt; int dir; int st; int act; int term; int err;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state
    int m_cnt, m_dir, m_st, m_term, m_err;
    bit p_ini, p_pau, p_inv;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    // Advance the model one clock using the inputs currently driven.
    task automatic model_update();
        bit ei, ep, ev, up, at_lim;
        if (!Reset) begin
            m_cnt = 0; m_dir = 0; m_st = ST_PARADO; m_term = 0; m_err = 0;
            p_ini = 1; p_pau = 1; p_inv = 1;
            return;
        end
        ei = iniciar && !p_ini;
        ep = pausar && !p_pau;
        ev = invertir && !p_inv;
        p_ini = iniciar; p_pau = pausar; p_inv = invertir;
        m_term = 0;
        if (ei) begin
            if (int'(limInf) <= int'(limSup)) begin
                m_err = 0;
                m_cnt = Direccion ? int'(limSup) : int'(limInf);
                m_st  = Direccion ? ST_BAJ : ST_SUB;
            end else begin
                m_err = 1;
                m_st  = ST_PARADO;
            end
        end else if (m_st == ST_SUB || m_st == ST_BAJ) begin
            up = (m_st == ST_SUB);
            if (ep) m_st = ST_PAUSA;
            else if (ev) m_st = up ? ST_BAJ : ST_SUB;
            else if (tick) begin
                at_lim = up ? (m_cnt >= int'(limSup)) : (m_cnt <= int'(limInf));
                if (!at_lim) begin
                    m_cnt = (up ? m_cnt + 1 : m_cnt - 1) % 16;
                end else begin
                    m_term = 1;
                    if (modo == 2'b01) begin
                        if (limSup > limInf) m_cnt = up ? int'(limSup) - 1 : int'(limInf) + 1;
                        m_st = up ? ST_BAJ : ST_SUB;
                    end else if (modo == 2'b10) begin
                        m_st = ST_PARADO;
                    end else begin
                        m_cnt = up ? int'(limInf) : int'(limSup);
                    end
                end
            end
        end else if (m_st == ST_PAUSA && ep) begin
            m_st = m_dir ? ST_BAJ : ST_SUB;
        end
        if (m_st == ST_SUB) m_dir = 0;
        else if (m_st == ST_BAJ) m_dir = 1;
    endtask

    // One clock: update the model, queue its expectation, and let the DUT take the edge.
    task automatic step();
        exp_t e;
        model_update();
        e.cnt = m_cnt; e.dir = m_dir; e.st = m_st; e.term = m_term; e.err = m_err;
        e.act = (m_st == ST_SUB || m_st == ST_BAJ) ? 1 : 0;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic pulse_ini();
        iniciar = 1'b1; step(); iniciar = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        for (int i = 0; i < n; i++) step();
        tick = 1'b0;
    endtask

    // Monitor: compares every registered output after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_contador",  int'(contador),  e.cnt);
                chk("sb_direccion", int'(direccion), e.dir);
                chk("sb_estado",    int'(estado),    e.st);
                chk("sb_activo",    int'(activo),    e.act);
                chk("sb_terminal",  int'(terminal),  e.term);
                chk("sb_error",     int'(error),     e.err);
            end
        end
    end

    initial begin
        Reset = 1'b0; tick = 1'b0; iniciar = 1'b1; pausar = 1'b0; invertir = 1'b0;
        Direccion = 1'b0; modo = 2'b00; limInf = 4'd2; limSup = 4'd5;
        @(negedge clk);

        // Reset with iniciar held: no start until it is released and pressed again
        step(); step();
        Reset = 1'b1;
        step(); step(); step();
        chk("held_ini_cnt", int'(contador), 0);
        chk("held_ini_st",  int'(estado), 0);
        iniciar = 1'b0; step();
        pulse_ini();
        chk("start_cnt", int'(contador), 2);
        chk("start_st",  int'(estado), 1);

        // Wrap 2..5
        ticks(4);
        chk("wrap_cnt",  int'(contador), 2);
        chk("wrap_term", int'(terminal), 1);
        ticks(1);
        chk("wrap_cnt2",  int'(contador), 3);
        chk("wrap_term2", int'(terminal), 0);

        // Ping-pong 2..5, eight ticks
        modo = 2'b01;
        pulse_ini();
        ticks(8);
        chk("pp_cnt", int'(contador), 4);
        chk("pp_dir", int'(direccion), 0);

        // One-shot down 3..0
        modo = 2'b10; Direccion = 1'b1; limInf = 4'd0; limSup = 4'd3;
        pulse_ini();
        ticks(4);
        chk("os_st",   int'(estado), 0);
        chk("os_cnt",  int'(contador), 0);
        chk("os_term", int'(terminal), 1);
        ticks(1);
        chk("os_hold", int'(contador), 0);

        // Pause at 4, ticks frozen, resume then step to 5
        modo = 2'b00; Direccion = 1'b0; limInf = 4'd2; limSup = 4'd5;
        pulse_ini();
        ticks(2);
        pausar = 1'b1; step(); pausar = 1'b0;
        ticks(3);
        chk("pause_cnt", int'(contador), 4);
        chk("pause_st",  int'(estado), 3);
        pausar = 1'b1; step(); pausar = 1'b0;
        ticks(1);
        chk("resume_cnt", int'(contador), 5);
        chk("resume_st",  int'(estado), 1);

        // Reverse coincident with a tick at 3
        pulse_ini();
        ticks(1);
        invertir = 1'b1; tick = 1'b1; step(); tick = 1'b0;
        chk("inv_cnt", int'(contador), 3);
        chk("inv_st",  int'(estado), 2);
        invertir = 1'b0;
        ticks(1);
        chk("inv_next", int'(contador), 2);

        // Inverted limits at start
        limInf = 4'd9; limSup = 4'd4;
        pulse_ini();
        chk("err_flag", int'(error), 1);
        chk("err_st",   int'(estado), 0);

        // Reset mid-count
        limInf = 4'd2; limSup = 4'd5;
        pulse_ini();
        ticks(1);
        Reset = 1'b0; step(); Reset = 1'b1;
        chk("rst_cnt", int'(contador), 0);
        chk("rst_st",  int'(estado), 0);
        chk("rst_act", int'(activo), 0);
        chk("rst_err", int'(error), 0);

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) iniciar  = ~iniciar;
            if ($urandom_range(0, 7) == 0) pausar   = ~pausar;
            if ($urandom_range(0, 7) == 0) invertir = ~invertir;
            tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) Direccion = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) modo = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) begin
                limInf = 4'($urandom_range(0, 15));
                limSup = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0 && limInf > limSup) begin
                    logic [3:0] t;
                    t = limInf; limInf = limSup; limSup = t;
                end
            end
            step();
        end

        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_conteo.md
# controlador_conteo

Run/pause/direction controller for a 4-bit up/down display counter on the Nexys 2. Takes debounced push-button levels and a one-cycle step enable from the clock divider, and sequences the count between programmable limits. Three limit policies: wrap, ping-pong and one-shot. Drives the value consumed by the display multiplexer and a terminal-count pulse for downstream logic.

## Interface
- WIDTH, 4, counter width in bits
- clkNexys2  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-low reset (0 = reset)
- tick  in  1  one-cycle step enable from clock divider
- iniciar  in  1  start/restart button level (debounced, synchronous)
- pausar  in  1  pause/resume button level
- invertir  in  1  reverse-direction button level
- Direccion  in  1  start direction switch: 0 = up, 1 = down
- modo  in  2  limit policy: 00 wrap, 01 ping-pong, 10 one-shot, 11 = wrap
- limInf  in  WIDTH  lower limit
- limSup  in  WIDTH  upper limit
- contador  out  WIDTH  current count (registered)
- direccion  out  1  current direction, 0 = up (registered)
- activo  out  1  1 in SUBIENDO/BAJANDO
- terminal  out  1  one-cycle pulse when a limit is reached on a step
- error  out  1  sticky: limInf > limSup at start
- estado  out  2  00 PARADO, 01 SUBIENDO, 10 BAJANDO, 11 PAUSA

## Operation
- Button edge detect: edge = level & ~prev; prev registered every cycle; prev resets to 1, so a button held through reset gives no edge until released.
- Priority per cycle: iniciar edge > pausar edge > invertir edge > tick.
- PARADO:
  - iniciar edge with limInf <= limSup: load contador = limInf (Direccion=0, go SUBIENDO) or limSup (Direccion=1, go BAJANDO); clear error.
  - iniciar edge with limInf > limSup: stay PARADO, set error, contador unchanged.
  - Other inputs ignored.
- SUBIENDO, tick:
  - contador < limSup: contador + 1.
  - contador == limSup: pulse terminal, then apply modo:
    - wrap: contador = limInf.
    - ping-pong: go BAJANDO; contador = limSup - 1 if limSup > limInf, else unchanged.
    - one-shot: hold contador, go PARADO.
- BAJANDO: mirror image; step -1; limit is limInf; ping-pong goes SUBIENDO with limInf + 1.
- Out-of-range value (limits changed mid-run, e.g. contador > limSup while up): treated as at limit on next tick; wrap reloads limInf.
- invertir edge while SUBIENDO/BAJANDO: swap state; no count change that cycle, even if tick is coincident.
- pausar edge while running: go PAUSA; remember direction in direccion. pausar edge in PAUSA: return to the remembered state. In PAUSA: tick and invertir ignored; contador frozen.
- iniciar edge in any state: restart as from PARADO, using current Direccion and limits.
- direccion: 0 in SUBIENDO, 1 in BAJANDO, held in PAUSA/PARADO.
- All arithmetic modulo 2^WIDTH; no overflow possible inside valid limits.

## Timing
- Reset (Reset=0 at a clock edge): contador=0, direccion=0, estado=PARADO, activo=0, terminal=0, error=0, prev=1 for all buttons. Reset overrides everything, including mid-count and PAUSA.
- Button edge acts on the same clock edge where level is first sampled high with prev=0; outputs visible the cycle after.
- tick step: contador updates on the edge where tick=1; latency 1 cycle.
- terminal is high for exactly the cycle following the limit step; never on load or restart.
- Holding a button produces one action only.

## Test plan
- Reset with iniciar held high, then release Reset -> contador=0, estado=00; no start until iniciar falls and rises again.
- limInf=2, limSup=5, modo=00, Direccion=0, start, 5 ticks -> contador 2,3,4,5,2,3; terminal one cycle after the 5->2 step.
- Same limits, modo=01, 8 ticks -> 2,3,4,5,4,3,2,3,4; terminal at 5 and at 2; direccion toggles at each limit.
- modo=10, Direccion=1, limSup=3, limInf=0 -> 3,2,1,0; estado=PARADO after 4th tick; contador holds 0.
- Running up at 4: pausar edge, 3 ticks, pausar edge, 1 tick -> holds 4 during PAUSA, then 5.
- invertir edge coincident with tick at 3 -> stays 3, estado=BAJANDO; next tick -> 2.
- limInf=9, limSup=4, iniciar edge -> error=1, estado=PARADO.
- Reset=0 mid-count -> all outputs at reset values next cycle.
